xlr8_xb_pinsample: RTL and testbench

Input-side companion to the XB pin-override mux. It takes the raw pin inputs, synchronizes and glitch-filters them, and broadcasts one clean pin-value vector to every Xcelerator Block. It detects rising and falling edges and keeps per-XB sticky pin-change flags with per-XB enable masks and write-1-to-clear. It sits between the pad inputs and the XB array, alongside the output pinmux, so XBs can sample pins without each instantiating its own synchronizers.

---
 rtl/xlr8_xb_pinsample.sv | 85 ++++++++
 tb/tb_xlr8_xb_pinsample.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xlr8_xb_pinsample.sv
// Pin-input sampler for the XB array: synchronizes and glitch-filters the pad inputs,
// then produces edge pulses and per-XB sticky pin-change flags and interrupts.
module xlr8_xb_pinsample #(
    parameter int NUM_PINS = 20,
    parameter int NUM_XBS  = 3,
    parameter int FILT_W   = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_PINS-1:0]                pins_in,
    input  logic [FILT_W-1:0]                  filt_len,
    input  logic [NUM_XBS-1:0][NUM_PINS-1:0]   xbs_pcmsk,
    input  logic [NUM_XBS-1:0][NUM_PINS-1:0]   xbs_pcclr,
    output logic [NUM_PINS-1:0]                xb_pinval,
    output logic [NUM_PINS-1:0]                xb_rise,
    output logic [NUM_PINS-1:0]                xb_fall,
    output logic [NUM_XBS-1:0][NUM_PINS-1:0]   xbs_pcflag,
    output logic [NUM_XBS-1:0]                 xbs_pcint
);

    logic [NUM_PINS-1:0] sync1;
    logic [NUM_PINS-1:0] sync2;
    logic [NUM_PINS-1:0] upd;
    logic [FILT_W-1:0]   cnt [NUM_PINS];

    // A pin accepts its new value once it has disagreed with xb_pinval for filt_len+1 cycles.
    always_comb begin
        upd = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            upd[p] = (sync2[p] != xb_pinval[p]) && (cnt[p] >= filt_len);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xb_pinval <= '0;
            xb_rise   <= '0;
            xb_fall   <= '0;
            for (int p = 0; p < NUM_PINS; p++) begin
                cnt[p] <= '0;
            end
        end else begin
            xb_pinval <= xb_pinval ^ upd;
            xb_rise   <= upd & sync2;
            xb_fall   <= upd & ~sync2;
            for (int p = 0; p < NUM_PINS; p++) begin
                if ((sync2[p] == xb_pinval[p]) || upd[p]) begin
                    cnt[p] <= '0;
                end else begin
                    cnt[p] <= cnt[p] + 1'b1;
                end
            end
        end
    end

    // NOTE: the set term is OR'd in after the clear so an edge coinciding with a clear is kept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xbs_pcflag <= '0;
        end else begin
            for (int i = 0; i < NUM_XBS; i++) begin
                xbs_pcflag[i] <= (xbs_pcflag[i] & ~xbs_pcclr[i]) | (upd & xbs_pcmsk[i]);
            end
        end
    end

    always_comb begin
        xbs_pcint = '0;
        for (int i = 0; i < NUM_XBS; i++) begin
            xbs_pcint[i] = |(xbs_pcflag[i] & xbs_pcmsk[i]);
        end
    end

endmodule

// File: tb/tb_xlr8_xb_pinsample.sv
// Self-checking bench for xlr8_xb_pinsample: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the pin sampler.
module tb_xlr8_xb_pinsample;

    localparam int NP = 20;
    localparam int NX = 3;
    localparam int FW = 4;

    logic                   clk;
    logic                   rstn;
    logic [NP-1:0]          pins_in;
    logic [FW-1:0]          filt_len;
    logic [NX-1:0][NP-1:0]  xbs_pcmsk;
    logic [NX-1:0][NP-1:0]  xbs_pcclr;
    logic [NP-1:0]          xb_pinval;
    logic [NP-1:0]          xb_rise;
    logic [NP-1:0]          xb_fall;
    logic [NX-1:0][NP-1:0]  xbs_pcflag;
    logic [NX-1:0]          xbs_pcint;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: two-stage delay line, consecutive-disagreement run length per pin.
    logic [NP-1:0]          m_d1, m_d2, m_v, m_rise, m_fall;
    logic [NX-1:0][NP-1:0]  m_flag;
    int                     m_run [NP];

    xlr8_xb_pinsample #(.NUM_PINS(NP), .NUM_XBS(NX), .FILT_W(FW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pins_in    (pins_in),
        .filt_len   (filt_len),
        .xbs_pcmsk  (xbs_pcmsk),
        .xbs_pcclr  (xbs_pcclr),
        .xb_pinval  (xb_pinval),
        .xb_rise    (xb_rise),
        .xb_fall    (xb_fall),
        .xbs_pcflag (xbs_pcflag),
        .xbs_pcint  (xbs_pcint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NX-1:0] exp_pcint();
        logic [NX-1:0] r;
        for (int i = 0; i < NX; i++) r[i] = |(m_flag[i] & xbs_pcmsk[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_v = '0; m_rise = '0; m_fall = '0; m_flag = '0;
        for (int p = 0; p < NP; p++) m_run[p] = 0;
    endtask

    // Advance the model with the inputs currently applied, then clock the DUT once.
    task automatic step();
        logic [NP-1:0] chg;
        chg = '0;
        for (int p = 0; p < NP; p++) begin
            if (m_d2[p] != m_v[p]) begin
                m_run[p] = m_run[p] + 1;
                if (m_run[p] >= int'(filt_len) + 1) begin
                    chg[p]   = 1'b1;
                    m_run[p] = 0;
                end
            end else begin
                m_run[p] = 0;
            end
        end
        m_rise = chg & m_d2;
        m_fall = chg & ~m_d2;
        m_v    = m_v ^ chg;
        for (int i = 0; i < NX; i++) m_flag[i] = (m_flag[i] & ~xbs_pcclr[i]) | (chg & xbs_pcmsk[i]);
        m_d2 = m_d1;
        m_d1 = pins_in;
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        pins_in = $urandom; filt_len = 4'd0; xbs_pcmsk = '1; xbs_pcclr = '0;
        rstn = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_tests++; if (xb_pinval !== '0) begin n_fail++; $display("FAIL reset_pinval: got %h expected 0", xb_pinval); end
        n_tests++; if (xb_rise !== '0) begin n_fail++; $display("FAIL reset_rise: got %h expected 0", xb_rise); end
        n_tests++; if (xb_fall !== '0) begin n_fail++; $display("FAIL reset_fall: got %h expected 0", xb_fall); end
        n_tests++; if (xbs_pcflag !== '0) begin n_fail++; $display("FAIL reset_flag: got %h expected 0", xbs_pcflag); end
        n_tests++; if (xbs_pcint !== '0) begin n_fail++; $display("FAIL reset_pcint: got %b expected 0", xbs_pcint); end
        pins_in = '0; xbs_pcmsk = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // N=3: change captured at edge 1 must appear at edge 1+2+3 = 6.
    task automatic test_debounce();
        filt_len = 4'd3;
        repeat (6) step();
        pins_in[5] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_tests++;
            if (xb_pinval[5] !== (e >= 6) || xb_rise[5] !== (e == 6) || xb_fall[5] !== 1'b0) begin
                n_fail++;
                $display("FAIL debounce_e%0d: got v=%b r=%b f=%b expected v=%b r=%b f=0",
                         e, xb_pinval[5], xb_rise[5], xb_fall[5], e >= 6, e == 6);
            end
        end
        n_tests++; if (xb_pinval !== m_v) begin n_fail++; $display("FAIL debounce_model: got %h expected %h", xb_pinval, m_v); end
        pins_in[5] = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_glitch();
        int bad, rise_at, fall_at, nr, nf;
        filt_len = 4'd3;
        bad = 0;
        pins_in[2] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (e == 4) pins_in[2] = 1'b0;
            step();
            if (xb_pinval[2] !== 1'b0 || xb_rise[2] !== 1'b0 || xb_fall[2] !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL glitch_reject: got %0d disturbed cycles expected 0", bad); end
        rise_at = 0; fall_at = 0; nr = 0; nf = 0;
        pins_in[2] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 5) pins_in[2] = 1'b0;
            step();
            if (xb_rise[2] === 1'b1) begin nr++; rise_at = e; end
            if (xb_fall[2] === 1'b1) begin nf++; fall_at = e; end
        end
        n_tests++; if (nr != 1 || rise_at != 6) begin n_fail++; $display("FAIL glitch_pass_rise: got %0d pulses at %0d expected 1 at 6", nr, rise_at); end
        n_tests++; if (nf != 1 || fall_at != 10) begin n_fail++; $display("FAIL glitch_pass_fall: got %0d pulses at %0d expected 1 at 10", nf, fall_at); end
    endtask

    task automatic test_nofilter();
        logic hist [64];
        int bad, nr, nf;
        filt_len = 4'd0;
        bad = 0; nr = 0; nf = 0;
        for (int e = 0; e < 40; e++) begin
            if (e % 4 == 0) pins_in[0] = ~pins_in[0];
            hist[e] = pins_in[0];
            step();
            if (e >= 2 && xb_pinval[0] !== hist[e-2]) bad++;
            if (xb_rise[0] !== m_rise[0] || xb_fall[0] !== m_fall[0]) bad++;
            if (xb_rise[0] === 1'b1) begin nr++; if (nr != nf + 1) bad++; end
            if (xb_fall[0] === 1'b1) begin nf++; if (nf != nr) bad++; end
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL nofilter_track: got %0d bad cycles expected 0", bad); end
        n_tests++; if (nr != 5 || nf != 5) begin n_fail++; $display("FAIL nofilter_count: got rise=%0d fall=%0d expected 5/5", nr, nf); end
        pins_in[0] = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_mask();
        filt_len = 4'd0;
        xbs_pcclr = '1; step(); xbs_pcclr = '0;
        xbs_pcmsk[0] = '0; xbs_pcmsk[1] = 20'h00010; xbs_pcmsk[2] = '0;
        pins_in[4] = 1'b1;
        repeat (4) step();
        n_tests++; if (xbs_pcflag !== {20'h0, 20'h00010, 20'h0}) begin n_fail++; $display("FAIL mask_flag: got %h expected %h", xbs_pcflag, {20'h0, 20'h00010, 20'h0}); end
        n_tests++; if (xbs_pcint !== 3'b010) begin n_fail++; $display("FAIL mask_pcint: got %b expected 010", xbs_pcint); end
        pins_in[3] = 1'b1;
        repeat (4) step();
        n_tests++; if (xbs_pcflag !== {20'h0, 20'h00010, 20'h0}) begin n_fail++; $display("FAIL mask_unmasked: got %h expected %h", xbs_pcflag, {20'h0, 20'h00010, 20'h0}); end
        xbs_pcmsk[1] = '0;
        #1;
        n_tests++; if (xbs_pcint !== 3'b000 || xbs_pcflag[1][4] !== 1'b1) begin n_fail++; $display("FAIL mask_drop: got pcint=%b flag=%b expected 000/1", xbs_pcint, xbs_pcflag[1][4]); end
        xbs_pcmsk[1] = 20'h00010;
        #1;
    endtask

    // N=0: falling pin 4 captured at edge 1 updates at edge 3, where the clear also lands.
    task automatic test_collision();
        pins_in[4] = 1'b0;
        step();
        step();
        xbs_pcclr[1][4] = 1'b1;
        step();
        xbs_pcclr[1][4] = 1'b0;
        n_tests++; if (xb_fall[4] !== 1'b1 || xbs_pcflag[1][4] !== 1'b1) begin n_fail++; $display("FAIL collision_set_wins: got fall=%b flag=%b expected 1/1", xb_fall[4], xbs_pcflag[1][4]); end
        xbs_pcclr[1][4] = 1'b1;
        step();
        xbs_pcclr[1][4] = 1'b0;
        n_tests++; if (xbs_pcflag[1][4] !== 1'b0 || xbs_pcint[1] !== 1'b0) begin n_fail++; $display("FAIL collision_clear: got flag=%b pcint=%b expected 0/0", xbs_pcflag[1][4], xbs_pcint[1]); end
    endtask

    task automatic test_reset_midfilter();
        int nr;
        filt_len = 4'd7;
        repeat (12) step();
        pins_in[9] = 1'b1;
        repeat (6) step();
        rstn = 1'b0;
        #1;
        n_tests++; if (xb_pinval !== '0 || xb_rise !== '0 || xb_fall !== '0) begin n_fail++; $display("FAIL midreset_pins: got v=%h r=%h f=%h expected 0", xb_pinval, xb_rise, xb_fall); end
        n_tests++; if (xbs_pcflag !== '0 || xbs_pcint !== '0) begin n_fail++; $display("FAIL midreset_flags: got %h/%b expected 0", xbs_pcflag, xbs_pcint); end
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        nr = 0;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (xb_rise[9] === 1'b1) nr++;
            n_tests++;
            if (xb_pinval[9] !== (e >= 10) || xb_rise[9] !== (e == 10)) begin
                n_fail++;
                $display("FAIL midreset_reacquire_e%0d: got v=%b r=%b expected v=%b r=%b", e, xb_pinval[9], xb_rise[9], e >= 10, e == 10);
            end
        end
        n_tests++; if (nr != 1) begin n_fail++; $display("FAIL midreset_rise_count: got %0d expected 1", nr); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) filt_len = FW'($urandom_range(0, 4));
            if (c % 50 == 0) for (int i = 0; i < NX; i++) xbs_pcmsk[i] = NP'($urandom);
            pins_in = pins_in ^ NP'($urandom & $urandom & $urandom & $urandom);
            for (int i = 0; i < NX; i++) xbs_pcclr[i] = NP'($urandom & $urandom & $urandom);
            step();
            n_tests++; if (xb_pinval !== m_v) begin n_fail++; $display("FAIL rand_pinval_c%0d: got %h expected %h", c, xb_pinval, m_v); end
            n_tests++; if (xb_rise !== m_rise) begin n_fail++; $display("FAIL rand_rise_c%0d: got %h expected %h", c, xb_rise, m_rise); end
            n_tests++; if (xb_fall !== m_fall) begin n_fail++; $display("FAIL rand_fall_c%0d: got %h expected %h", c, xb_fall, m_fall); end
            n_tests++; if (xbs_pcflag !== m_flag) begin n_fail++; $display("FAIL rand_flag_c%0d: got %h expected %h", c, xbs_pcflag, m_flag); end
            n_tests++; if (xbs_pcint !== exp_pcint()) begin n_fail++; $display("FAIL rand_pcint_c%0d: got %b expected %b", c, xbs_pcint, exp_pcint()); end
        end
        xbs_pcclr = '0;
    endtask

    initial begin
        rstn = 1'b0; pins_in = '0; filt_len = '0; xbs_pcmsk = '0; xbs_pcclr = '0;
        model_reset();
        test_reset();
        test_debounce();
        test_glitch();
        test_nofilter();
        test_mask();
        test_collision();
        test_reset_midfilter();
        hold_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
